// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - binary32 field widths, word layout and NaN helpers
package fp32_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FP_W  = 1 + EXP_W + MAN_W;

    localparam logic [FP_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic is_nan(input fp32_t f);
        return (&f.exp) && (|f.man);
    endfunction

endpackage

// File: rtl/fp32_max_reg_if.sv
// rtl/fp32_max_reg_if.sv - operand/result bundle for the registered fp max
interface fp32_max_reg_if
    import fp32_pkg::*;
#(
    parameter int W = FP_W
);
    logic         in_valid;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic         out_valid;
    logic [W-1:0] out;
    logic         sel_b;
    logic         nan_out;

    modport master (
        output in_valid, inputA, inputB,
        input  out_valid, out, sel_b, nan_out
    );

    modport slave (
        input  in_valid, inputA, inputB,
        output out_valid, out, sel_b, nan_out
    );
endinterface

// File: rtl/fp32_gt_cmp.sv
// rtl/fp32_gt_cmp.sv - sign-magnitude strict greater-than with NaN flags
module fp32_gt_cmp
    import fp32_pkg::*;
#(
    parameter int EXP_W_P = EXP_W,
    parameter int MAN_W_P = MAN_W,
    parameter int W       = 1 + EXP_W_P + MAN_W_P
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_gt_b,
    output logic         a_nan,
    output logic         b_nan
);
    logic                       sign_a, sign_b;
    logic [EXP_W_P+MAN_W_P-1:0] mag_a, mag_b;

    assign sign_a = a[W-1];
    assign sign_b = b[W-1];
    assign mag_a  = a[W-2:0];
    assign mag_b  = b[W-2:0];

    assign a_nan = (&a[W-2 -: EXP_W_P]) && (|a[MAN_W_P-1:0]);
    assign b_nan = (&b[W-2 -: EXP_W_P]) && (|b[MAN_W_P-1:0]);

    // Mixed signs: the positive word wins, which also ranks +0 above -0.
    always_comb begin
        a_gt_b = 1'b0;
        if (sign_a != sign_b)
            a_gt_b = ~sign_a;
        else if (!sign_a)
            a_gt_b = (mag_a > mag_b);
        else
            a_gt_b = (mag_a < mag_b);
    end
endmodule

// File: rtl/fp32_max_reg.sv
// rtl/fp32_max_reg.sv - registered maximumNumber of two binary32 operands
module fp32_max_reg
    import fp32_pkg::*;
#(
    parameter int EXP_W = fp32_pkg::EXP_W,
    parameter int MAN_W = fp32_pkg::MAN_W
) (
    input  logic           clk,
    input  logic           rst_n,
    fp32_max_reg_if.slave  bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic         a_gt_b, a_nan, b_nan;
    logic [W-1:0] res;
    logic         res_sel_b, res_nan;

    logic [W-1:0] out_d, out_q;
    logic         out_valid_d, out_valid_q;
    logic         sel_b_d, sel_b_q;
    logic         nan_out_d, nan_out_q;

    fp32_gt_cmp #(
        .EXP_W_P (EXP_W),
        .MAN_W_P (MAN_W)
    ) u_cmp (
        .a      (bus.inputA),
        .b      (bus.inputB),
        .a_gt_b (a_gt_b),
        .a_nan  (a_nan),
        .b_nan  (b_nan)
    );

    // A single NaN yields the other operand; only a double NaN produces the canonical qNaN.
    always_comb begin
        res       = bus.inputA;
        res_sel_b = 1'b0;
        res_nan   = 1'b0;
        if (a_nan && b_nan) begin
            res       = QNAN;
            res_sel_b = 1'b1;
            res_nan   = 1'b1;
        end else if (a_nan) begin
            res       = bus.inputB;
            res_sel_b = 1'b1;
        end else if (b_nan || a_gt_b || (bus.inputA == bus.inputB)) begin
            res       = bus.inputA;
            res_sel_b = 1'b0;
        end else begin
            res       = bus.inputB;
            res_sel_b = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = bus.in_valid;
        out_d       = out_q;
        sel_b_d     = sel_b_q;
        nan_out_d   = nan_out_q;
        if (bus.in_valid) begin
            out_d     = res;
            sel_b_d   = res_sel_b;
            nan_out_d = res_nan;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sel_b_q     <= 1'b0;
            nan_out_q   <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sel_b_q     <= sel_b_d;
            nan_out_q   <= nan_out_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_b     = sel_b_q;
    assign bus.nan_out   = nan_out_q;
endmodule

// File: tb/tb_fp32_max_reg.sv
// tb/tb_fp32_max_reg.sv - randomized and directed check of fp32_max_reg against an ordering-key model
module tb_fp32_max_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] exp_out;
    logic        exp_sel;
    logic        exp_nan;

    fp32_max_reg_if #(.W(32)) bus ();

    fp32_max_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit m_is_nan(input logic [31:0] x);
        return (((x >> 23) & 32'hFF) == 32'hFF) && ((x & 32'h7FFFFF) != 0);
    endfunction

    // Map each non-NaN word onto a signed integer line; -0 lands just below +0.
    function automatic longint order_key(input logic [31:0] x);
        longint mag;
        mag = longint'(x & 32'h7FFF_FFFF);
        return x[31] ? (-mag - 1) : mag;
    endfunction

    task automatic model(input logic [31:0] a, input logic [31:0] b);
        exp_nan = 1'b0;
        if (m_is_nan(a) && m_is_nan(b)) begin
            exp_out = 32'h7FC0_0000; exp_sel = 1'b1; exp_nan = 1'b1;
        end else if (m_is_nan(a)) begin
            exp_out = b; exp_sel = 1'b1;
        end else if (m_is_nan(b)) begin
            exp_out = a; exp_sel = 1'b0;
        end else if (order_key(a) >= order_key(b)) begin
            exp_out = a; exp_sel = 1'b0;
        end else begin
            exp_out = b; exp_sel = 1'b1;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".out"},   bus.out, exp_out);
        check({tag, ".sel_b"}, {31'd0, bus.sel_b}, {31'd0, exp_sel});
        check({tag, ".nan"},   {31'd0, bus.nan_out}, {31'd0, exp_nan});
    endtask

    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.inputA   = a;
        bus.inputB   = b;
        model(a, b);
        @(posedge clk);
        #1;
        check_result(tag);
    endtask

    function automatic logic [31:0] pick_word();
        logic [31:0] w;
        logic [31:0] specials [8];
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'hFF80_0001, 32'h0000_0001, 32'h8000_0001};
        case ($urandom_range(0, 4))
            0:       w = specials[$urandom_range(0, 7)];
            1:       w = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom)};
            2:       w = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom)};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] a, b, last;
        bus.in_valid = 1'b1;
        bus.inputA   = 32'hDEAD_BEEF;
        bus.inputB   = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out",   bus.out, 32'h0);
        check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.sel_b", {31'd0, bus.sel_b}, 32'd0);
        check("rst.nan",   {31'd0, bus.nan_out}, 32'd0);
        rst_n = 1'b1;

        apply("pos_a",     32'h4060_0000, 32'h4020_0000);
        apply("pos_b",     32'h4060_0000, 32'h4220_0000);
        apply("neg",       32'hC060_0000, 32'hC020_0000);
        apply("mix1",      32'h4060_0000, 32'hC220_0000);
        apply("mix2",      32'h4060_0000, 32'hC020_0000);
        apply("zeros",     32'h8000_0000, 32'h0000_0000);
        apply("zeros_r",   32'h0000_0000, 32'h8000_0000);
        apply("qnan_a",    32'h7FC0_0001, 32'hC020_0000);
        apply("snan_b",    32'hFF80_0000, 32'h7F80_0001);
        apply("both_nan",  32'h7F80_0001, 32'hFFC0_1234);
        apply("pinf",      32'h7F80_0000, 32'h4220_0000);
        apply("equal",     32'h4220_0000, 32'h4220_0000);
        apply("subnorm",   32'h0000_0001, 32'h0000_0000);

        for (int i = 0; i < 300; i++) begin
            a = pick_word();
            b = ($urandom_range(0, 9) == 0) ? a : pick_word();
            apply($sformatf("rnd%0d", i), a, b);
        end

        last = exp_out;
        bus.in_valid = 1'b0;
        bus.inputA   = 32'h3F80_0000;
        bus.inputB   = 32'h7F80_0000;
        repeat (2) @(posedge clk);
        #1;
        check("hold.valid", {31'd0, bus.out_valid}, 32'd0);
        check("hold.out",   bus.out, last);
        check("hold.sel_b", {31'd0, bus.sel_b}, {31'd0, exp_sel});

        apply("pre_rst", 32'h7F80_0001, 32'h7F80_0002);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out",   bus.out, 32'h0);
        check("arst.valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst.nan",   {31'd0, bus.nan_out}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("post_rst", 32'h0000_0001, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/fp32_max_reg.md
Name: fp32_max_reg

Overview:
- Returns the larger of two IEEE-754 binary32 operands, selected bit-exactly from the inputs with no rounding.
- Used as a reduction/activation primitive in the TPU datapath, for example in max-pooling and ReLU-style clamps.
- A combinational comparator drives a single output register stage, with a valid qualifier alongside the data.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: mantissa field width. Total word width is 1+EXP_W+MAN_W, which is 32 by default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  inputA/inputB are valid this cycle.
- inputA  input  32  operand A (binary32 bits).
- inputB  input  32  operand B (binary32 bits).
- out_valid  output  1  out holds a valid result.
- out  output  32  max(A,B) bits.
- sel_b  output  1  1 means out was taken from inputB (or is the canonical NaN); 0 means from inputA.
- nan_out  output  1  both operands were NaN; out is the canonical qNaN.

Behaviour:
- Reset: while rst_n=0, and asynchronously on its falling edge, out=32'h0, out_valid=0, sel_b=0, nan_out=0.
- Latency is 1 cycle. Operands are sampled at edge N when in_valid=1; the result appears after edge N and persists until the next accepted operand pair.
  - out_valid is a registered copy of in_valid.
  - When in_valid=0, out, sel_b and nan_out hold their values; only out_valid drops.
  - There is no backpressure: a new pair can be accepted every cycle.
- Field decode: sign = bit 31, exp = bits 30:23, man = bits 22:0.
  - NaN: exp all ones and man≠0. Infinity: exp all ones and man=0. Subnormals are compared as-is, never flushed.
- Ordering rules (non-NaN operands):
  - Different signs: the positive operand wins. +0 beats -0.
  - Both positive: the larger magnitude field {exp,man} wins, using an unsigned compare.
  - Both negative: the smaller magnitude field wins.
  - Equal bit patterns: A is returned and sel_b=0.
  - Infinities fall out of the magnitude compare: +Inf beats everything, and -Inf loses to everything except a NaN-only case.
- NaN rules (maximumNumber semantics):
  - Exactly one operand NaN: return the other operand unchanged.
  - Both NaN: out=32'h7FC00000 with nan_out=1 and sel_b=1.
  - Signalling and quiet NaNs are treated identically; no exception flags are produced.
- The output is always one of the input words or the canonical NaN. No arithmetic is performed on the data.
- Reset asserted mid-stream discards any in-flight result. The first in_valid after rst_n rises behaves normally.

Decomposition:
- Package fp32_pkg holds:
  - EXP_W/MAN_W constants
  - a packed struct typedef {sign, exp, man}
  - localparam FP32_QNAN = 32'h7FC00000
  - a function is_nan()
- One combinational sub-module, fp32_gt_cmp, takes a, b and outputs a_gt_b, a_nan, b_nan. It implements the sign-magnitude total order above.
- The top level fp32_max_reg instantiates fp32_gt_cmp, applies the NaN and tie muxing, and holds the output registers.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> out=0, out_valid=0. Release rst_n, send A=0x40600000 (3.5), B=0x40200000 (2.5) -> next cycle out=0x40600000, sel_b=0, out_valid=1.
- Same sign: A=3.5, B=0x42200000 (40.0) -> out=0x42200000, sel_b=1. A=0xC0600000 (-3.5), B=0xC0200000 (-2.5) -> out=0xC0200000.
- Mixed sign:
  - A=3.5, B=0xC2200000 (-40.0) -> out=0x40600000.
  - A=3.5, B=0xC0200000 (-2.5) -> out=0x40600000.
  - A=0x80000000 (-0), B=0x00000000 (+0) -> out=0x00000000, sel_b=1.
- NaN/Inf:
  - A=0x7FC00001, B=0xC0200000 -> out=0xC0200000.
  - A=0xFF800000 (-Inf), B=0x7F800001 (sNaN) -> out=0xFF800000.
  - Both NaN -> out=0x7FC00000, nan_out=1.
  - A=0x7F800000 (+Inf), B=0x42200000 -> out=0x7F800000.
- Streaming/hold: drive 4 back-to-back valid pairs -> 4 consecutive correct results, each 1 cycle late. Drop in_valid -> out_valid=0 and out holds the last result.
- Reset mid-operation: assert rst_n=0 asynchronously between clock edges with out_valid=1 -> out and out_valid clear immediately, without waiting for clk. Subnormal check: A=0x00000001, B=0x00000000 -> out=0x00000001.
